data_memory_arbiter: RTL and testbench

Single-clock arbiter sharing the one data memory port between the GPP load/store path and the communications processor's packet-buffer path. Sits in the computer top level between both requesters and the data memory. It grants one word access per cycle, with fixed GPP priority and a starvation guard for the comms side. It also returns registered read data to whichever requester issued the read.

---
 rtl/data_memory_arbiter_pkg.sv | 14 +
 rtl/data_memory_arbiter.sv | 122 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the data memory arbiter: grant encoding and wait counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_GPP  = 2'd1,
    GNT_CP   = 2'd2
  } grant_t;

  localparam int WAIT_CNT_W = 3;

endpackage

// File: rtl/data_memory_arbiter.sv
// Shares one data memory port between the GPP and CP; fixed GPP priority with a CP starvation guard.
// Latency: req in cycle n -> gnt/transfer in n+1 -> rvalid/rdata in n+2.
// Backpressure: a requester holds req and payload until it sees gnt; transfer = req && gnt.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   gpp_req/we/addr/wdata    GPP access request and payload
//   gpp_gnt/rdata/rvalid     GPP grant offer, registered read return
//   cp_*                     same set for the communications processor
//   mem_we/addr/wdata        data memory port, muxed from the granted side
//   mem_rdata                data memory read data (combinational from mem_addr)
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gpp_req,
  input  logic              gpp_we,
  input  logic [ADDR_W-1:0] gpp_addr,
  input  logic [DATA_W-1:0] gpp_wdata,
  output logic              gpp_gnt,
  output logic [DATA_W-1:0] gpp_rdata,
  output logic              gpp_rvalid,
  input  logic              cp_req,
  input  logic              cp_we,
  input  logic [ADDR_W-1:0] cp_addr,
  input  logic [DATA_W-1:0] cp_wdata,
  output logic              cp_gnt,
  output logic [DATA_W-1:0] cp_rdata,
  output logic              cp_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  grant_t                grant_q, grant_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic                  gpp_gnt_q, cp_gnt_q;
  logic                  gpp_rvalid_q, cp_rvalid_q;
  logic [DATA_W-1:0]     gpp_rdata_q, cp_rdata_q;
  logic                  cp_wins;
  logic                  gpp_rd_xfer, cp_rd_xfer;

  always_comb begin
    // CP takes the port when GPP is idle, or once it has been denied MAX_WAIT times in a row.
    cp_wins = cp_req && (!gpp_req || (wait_q == MAX_WAIT_C));

    grant_d = GNT_NONE;
    if (cp_wins) begin
      grant_d = GNT_CP;
    end else if (gpp_req) begin
      grant_d = GNT_GPP;
    end

    wait_d = wait_q;
    if (!cp_req || cp_wins) begin
      wait_d = '0;
    end else if (wait_q != MAX_WAIT_C) begin
      wait_d = wait_q + 1'b1;
    end

    gpp_rd_xfer = gpp_gnt_q && gpp_req && !gpp_we;
    cp_rd_xfer  = cp_gnt_q  && cp_req  && !cp_we;
  end

  // Port mux: driven straight from the grant register, so reset forces it to zero at once.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gpp_gnt_q) begin
      mem_we    = gpp_req && gpp_we;
      mem_addr  = gpp_addr;
      mem_wdata = gpp_wdata;
    end else if (cp_gnt_q) begin
      mem_we    = cp_req && cp_we;
      mem_addr  = cp_addr;
      mem_wdata = cp_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q      <= GNT_NONE;
      wait_q       <= '0;
      gpp_gnt_q    <= 1'b0;
      cp_gnt_q     <= 1'b0;
      gpp_rvalid_q <= 1'b0;
      cp_rvalid_q  <= 1'b0;
      gpp_rdata_q  <= '0;
      cp_rdata_q   <= '0;
    end else begin
      grant_q      <= grant_d;
      wait_q       <= wait_d;
      gpp_gnt_q    <= (grant_d == GNT_GPP);
      cp_gnt_q     <= (grant_d == GNT_CP);
      gpp_rvalid_q <= gpp_rd_xfer;
      cp_rvalid_q  <= cp_rd_xfer;
      if (gpp_rd_xfer) begin
        gpp_rdata_q <= mem_rdata;
      end
      if (cp_rd_xfer) begin
        cp_rdata_q <= mem_rdata;
      end
    end
  end

  assign gpp_gnt    = gpp_gnt_q;
  assign cp_gnt     = cp_gnt_q;
  assign gpp_rvalid = gpp_rvalid_q;
  assign cp_rvalid  = cp_rvalid_q;
  assign gpp_rdata  = gpp_rdata_q;
  assign cp_rdata   = cp_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus random traffic against a behavioural model.
// Latency: model predicts grant one cycle after req, read data one cycle after transfer.
// Backpressure: stimulus holds req/payload until the model sees a transfer.
module tb_data_memory_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gpp_req = 1'b0, gpp_we = 1'b0;
  logic [AW-1:0] gpp_addr = '0;
  logic [DW-1:0] gpp_wdata = '0;
  logic          cp_req = 1'b0, cp_we = 1'b0;
  logic [AW-1:0] cp_addr = '0;
  logic [DW-1:0] cp_wdata = '0;
  logic          gpp_gnt, gpp_rvalid, cp_gnt, cp_rvalid, mem_we;
  logic [DW-1:0] gpp_rdata, cp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .gpp_req(gpp_req), .gpp_we(gpp_we), .gpp_addr(gpp_addr), .gpp_wdata(gpp_wdata),
    .gpp_gnt(gpp_gnt), .gpp_rdata(gpp_rdata), .gpp_rvalid(gpp_rvalid),
    .cp_req(cp_req), .cp_we(cp_we), .cp_addr(cp_addr), .cp_wdata(cp_wdata),
    .cp_gnt(cp_gnt), .cp_rdata(cp_rdata), .cp_rvalid(cp_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment memory, driven by whatever the DUT presents on its port.
  logic [DW-1:0] em [0:65535];
  assign mem_rdata = em[mem_addr];
  always @(posedge clk) if (mem_we) em[mem_addr] <= mem_wdata;

  // Behavioural model: who owns the port this cycle, how long CP has been refused,
  // and the read return each requester should see. Model memory is separate.
  logic [DW-1:0] mm [0:65535];
  int            m_owner = 0;   // 0 nobody, 1 GPP, 2 CP
  int            m_refused = 0;
  logic          m_grv = 1'b0, m_crv = 1'b0;
  logic [DW-1:0] m_grd = '0, m_crd = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner <= 0; m_refused <= 0;
      m_grv <= 1'b0; m_crv <= 1'b0; m_grd <= '0; m_crd <= '0;
    end else begin
      m_grv <= (m_owner == 1) && gpp_req && !gpp_we;
      m_crv <= (m_owner == 2) && cp_req && !cp_we;
      if ((m_owner == 1) && gpp_req) begin
        if (gpp_we) mm[gpp_addr] <= gpp_wdata; else m_grd <= mm[gpp_addr];
      end
      if ((m_owner == 2) && cp_req) begin
        if (cp_we) mm[cp_addr] <= cp_wdata; else m_crd <= mm[cp_addr];
      end
      if (cp_req && (!gpp_req || m_refused >= MW)) begin
        m_owner <= 2; m_refused <= 0;
      end else begin
        m_owner <= gpp_req ? 1 : 0;
        m_refused <= cp_req ? ((m_refused + 1 > MW) ? MW : m_refused + 1) : 0;
      end
    end
  end

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic          eg, ec, ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      eg  = rst && (m_owner == 1);
      ec  = rst && (m_owner == 2);
      ewe = eg ? (gpp_req && gpp_we) : ec ? (cp_req && cp_we) : 1'b0;
      ea  = eg ? gpp_addr  : ec ? cp_addr  : '0;
      ed  = eg ? gpp_wdata : ec ? cp_wdata : '0;
      check("gpp_gnt", 32'(gpp_gnt), 32'(eg));
      check("cp_gnt", 32'(cp_gnt), 32'(ec));
      check("mem_we", 32'(mem_we), 32'(ewe));
      check("mem_addr", 32'(mem_addr), 32'(ea));
      check("mem_wdata", 32'(mem_wdata), 32'(ed));
      check("gpp_rvalid", 32'(gpp_rvalid), 32'(m_grv));
      check("cp_rvalid", 32'(cp_rvalid), 32'(m_crv));
      check("gpp_rdata", 32'(gpp_rdata), 32'(m_grd));
      check("cp_rdata", 32'(cp_rdata), 32'(m_crd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] pat;
    int         ngpp;
    logic       g_x, c_x;

    for (int i = 0; i < 65536; i++) begin
      em[i] = 16'(i) ^ 16'hA5A5;
      mm[i] = 16'(i) ^ 16'hA5A5;
    end
    em[16'h0020] = 16'h1234; mm[16'h0020] = 16'h1234;
    em[16'h0030] = 16'h5555; mm[16'h0030] = 16'h5555;

    // Reset held with both requesters asking for reads.
    gpp_req = 1'b1; gpp_addr = 16'h0000;
    cp_req  = 1'b1; cp_addr  = 16'h0001;
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gpp_gnt", 32'(gpp_gnt), 32'd0);
    check("rst_cp_rvalid", 32'(cp_rvalid), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rel_gnt_same_cycle", 32'(gpp_gnt), 32'd0);

    // Contention: 4 GPP grants then one CP grant, repeating.
    @(negedge clk);
    check("rel_gnt_next_cycle", 32'(gpp_gnt), 32'd1);
    pat = '0; ngpp = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      pat[i] = cp_gnt;
      ngpp += int'(gpp_gnt);
    end
    check("contention_cp_pattern", 32'(pat), 32'(10'b10_0001_0000));
    check("contention_gpp_count", 32'(ngpp), 32'd8);
    tick();
    gpp_req = 1'b0; cp_req = 1'b0;
    repeat (3) tick();

    // GPP write then read back, with an idle grant after dropping req.
    gpp_req = 1'b1; gpp_we = 1'b1; gpp_addr = 16'h0010; gpp_wdata = 16'hBEEF;
    tick();
    @(negedge clk);
    check("gw_gnt", 32'(gpp_gnt), 32'd1);
    check("gw_mem_we", 32'(mem_we), 32'd1);
    check("gw_mem_addr", 32'(mem_addr), 32'h0010);
    tick();
    gpp_we = 1'b0;
    @(negedge clk);
    check("gr_mem_we", 32'(mem_we), 32'd0);
    check("gr_rvalid_early", 32'(gpp_rvalid), 32'd0);
    tick();
    gpp_req = 1'b0;
    @(negedge clk);
    check("gr_rvalid", 32'(gpp_rvalid), 32'd1);
    check("gr_rdata", 32'(gpp_rdata), 32'h0000BEEF);
    check("idle_gnt", 32'(gpp_gnt), 32'd1);
    check("idle_mem_we", 32'(mem_we), 32'd0);
    tick();
    @(negedge clk);
    check("idle_done_gnt", 32'(gpp_gnt), 32'd0);
    check("idle_no_rvalid", 32'(gpp_rvalid), 32'd0);

    // CP read of a preloaded word.
    tick();
    cp_req = 1'b1; cp_we = 1'b0; cp_addr = 16'h0020;
    tick();
    @(negedge clk);
    check("cr_gnt", 32'(cp_gnt), 32'd1);
    tick();
    cp_req = 1'b0;
    @(negedge clk);
    check("cr_rvalid", 32'(cp_rvalid), 32'd1);
    check("cr_rdata", 32'(cp_rdata), 32'h00001234);
    check("cr_gpp_rvalid", 32'(gpp_rvalid), 32'd0);
    repeat (2) tick();

    // Reset in the middle of a CP write grant: the write must not land.
    cp_req = 1'b1; cp_we = 1'b1; cp_addr = 16'h0030; cp_wdata = 16'hDEAD;
    tick();
    check("rw_mem_we_before", 32'(mem_we), 32'd1);
    #1;
    rst = 1'b0; cp_req = 1'b0; cp_we = 1'b0;
    #1;
    check("rw_mem_we_after", 32'(mem_we), 32'd0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    gpp_req = 1'b1; gpp_we = 1'b0; gpp_addr = 16'h0030;
    tick();
    tick();
    gpp_req = 1'b0;
    @(negedge clk);
    check("rw_readback_valid", 32'(gpp_rvalid), 32'd1);
    check("rw_readback_data", 32'(gpp_rdata), 32'h00005555);
    repeat (2) tick();

    // Random traffic; each side holds its request until the model sees it transfer.
    g_x = 1'b0; c_x = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      g_x = (m_owner == 1) && gpp_req;
      c_x = (m_owner == 2) && cp_req;
      tick();
      if (g_x || !gpp_req) begin
        if ($urandom_range(0, 9) < 7) begin
          gpp_req = 1'b1; gpp_we = 1'($urandom_range(0, 1));
          gpp_addr = 16'($urandom_range(0, 15)); gpp_wdata = 16'($urandom);
        end else begin
          gpp_req = 1'b0;
        end
      end
      if (c_x || !cp_req) begin
        if ($urandom_range(0, 9) < 5) begin
          cp_req = 1'b1; cp_we = 1'($urandom_range(0, 1));
          cp_addr = 16'($urandom_range(0, 15)); cp_wdata = 16'($urandom);
        end else begin
          cp_req = 1'b0;
        end
      end
    end
    gpp_req = 1'b0; cp_req = 1'b0;
    repeat (3) tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
